// File: rtl/load_store_unit.sv
// Load/store unit: drives a word-addressed data memory for byte, halfword
// and word accesses. Sub-word stores are read-modify-write; loads return
// sign- or zero-extended data with a one-cycle done pulse.
module load_store_unit #(
  parameter int WORD_ADDR_BITS = 6,
  parameter int CHECK_RANGE    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Byte-address bits above the decoded memory must be zero to be in range.
  localparam logic [32:0] LIMIT      = 33'd1 << (2 + WORD_ADDR_BITS);
  localparam logic [31:0] LIMIT_LO   = LIMIT[31:0];
  localparam logic [31:0] RANGE_MASK = ~(LIMIT_LO - 32'd1);

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        is_store_q, is_store_d;
  logic        unsigned_q, unsigned_d;
  logic [15:0] store_lo_q, store_lo_d;
  logic        err_q, err_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] load_data_q, load_data_d;

  logic        req_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Classify an incoming request: illegal size, misalignment or out of range.
  always_comb begin
    req_bad = 1'b0;
    if (size == 2'b11) req_bad = 1'b1;
    if (size == 2'b01 && addr[0]) req_bad = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00) req_bad = 1'b1;
    if (CHECK_RANGE != 0 && (addr & RANGE_MASK) != 32'd0) req_bad = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel = Read_data[8*lane_q +: 8];
    half_sel = lane_q[1] ? Read_data[31:16] : Read_data[15:0];
    load_ext = Read_data;
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = unsigned_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = Read_data;
    endcase
    merged = Read_data;
    if (size_q == 2'b00) begin
      merged[8*lane_q +: 8] = store_lo_q[7:0];
    end else if (lane_q[1]) begin
      merged[31:16] = store_lo_q;
    end else begin
      merged[15:0] = store_lo_q;
    end
  end

  // Next-state logic: accept in IDLE, then walk READ/WRITE to DONE.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    size_d       = size_q;
    is_store_d   = is_store_q;
    unsigned_d   = unsigned_q;
    store_lo_d   = store_lo_q;
    err_d        = err_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    load_data_d  = load_data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          lane_d     = addr[1:0];
          size_d     = size;
          is_store_d = is_store;
          unsigned_d = unsigned_ld;
          store_lo_d = store_data[15:0];
          err_d      = req_bad;
          if (req_bad) begin
            state_d = DONE;
          end else begin
            address_d = {2'b00, addr[31:2]};
            if (is_store && size == 2'b10) begin
              write_data_d = store_data;
              state_d      = WRITE;
            end else begin
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (is_store_q) begin
          write_data_d = merged;
          state_d      = WRITE;
        end else begin
          load_data_d = load_ext;
          state_d     = DONE;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lane_q       <= 2'd0;
      size_q       <= 2'd0;
      is_store_q   <= 1'b0;
      unsigned_q   <= 1'b0;
      store_lo_q   <= 16'd0;
      err_q        <= 1'b0;
      address_q    <= 32'd0;
      write_data_q <= 32'd0;
      load_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      is_store_q   <= is_store_d;
      unsigned_q   <= unsigned_d;
      store_lo_q   <= store_lo_d;
      err_q        <= err_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      load_data_q  <= load_data_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == DONE) && err_q;
  assign MemRead    = (state_q == READ);
  assign MemWrite   = (state_q == WRITE);
  assign Address    = address_q;
  assign Write_data = write_data_q;
  assign load_data  = load_data_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator for the data memory port; sits between the core's execute stage and the word-addressed data memory.
- Accepts one byte, halfword or word load/store request at a time and drives MemRead, MemWrite, Address and Write_data.
- Sub-word stores are done as read-modify-write over the 32-bit memory word.
- Returns sign- or zero-extended load data with a one-cycle done pulse; flags misaligned, illegal and out-of-range requests without touching memory.

Parameters:
- WORD_ADDR_BITS, 6: number of word-index bits the memory decodes; depth = 2^WORD_ADDR_BITS words.
- CHECK_RANGE, 1: 1 = flag an error when byte address bits [31:2+WORD_ADDR_BITS] are nonzero; 0 = no range check.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request valid; sampled only when busy=0.
- is_store  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- unsigned_ld  in  1  1 = zero-extend sub-word load, 0 = sign-extend.
- addr  in  32  byte address.
- store_data  in  32  store value, right-justified for sub-word stores.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = misaligned, illegal size or out of range; no memory access was made.
- load_data  out  32  extended load result; valid when done=1 and held until the next accepted request.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable; one cycle per store.
- Address  out  32  word index, equal to {2'b00, addr[31:2]}.
- Write_data  out  32  word to be written.
- Read_data  in  32  combinational read data from memory, valid in the same cycle as MemRead.

Behaviour:
- Reset: on the reset edge the state goes to IDLE and every output is cleared: busy, done, err, MemRead and MemWrite = 0; load_data, Address and Write_data = 0.
- Reset in any state aborts the operation at that edge. Any write not yet issued is not issued.
- FSM states: IDLE, READ, WRITE, DONE. MemRead=1 only in READ and MemWrite=1 only in WRITE, both decoded from the state register.
- Accept: a request is accepted only in IDLE with req=1. addr, size, is_store, unsigned_ld and store_data are captured into registers. req in any other state is ignored.
- Checks at accept time:
  - size=11 -> error.
  - size=01 with addr[0]=1 -> error.
  - size=10 with addr[1:0] not 00 -> error.
  - CHECK_RANGE=1 and out-of-range address -> error.
  - Any error goes IDLE->DONE with err=1 and no MemRead/MemWrite.
- Transitions:
  - load: IDLE->READ->DONE.
  - word store: IDLE->WRITE->DONE.
  - sub-word store: IDLE->READ->WRITE->DONE.
  - DONE->IDLE always.
- Latency, counted from the accept edge: done is high in cycle 2 for loads and word stores, cycle 3 for sub-word stores, and cycle 1 for errors.
- Address and Write_data are registered. They are stable for the whole READ/WRITE cycle and change only on the edge entering READ or WRITE; Write_data is held otherwise.
- READ: Read_data is captured into the word register on the edge leaving READ.
- Lanes are little-endian: byte k = bits [8k+7:8k]. Byte lane = addr[1:0]; halfword lane = addr[1] (low half if 0).
- Load extraction: select the byte or halfword, then sign-extend from bit 7/15 unless unsigned_ld=1. Word loads pass through unchanged.
- Store merge: replace only the selected lane of the captured word with store_data[7:0] or [15:0]; all other bytes are unchanged. Word stores write store_data directly with no read.
- load_data updates only at load completion, on the edge entering DONE. Stores and errors leave load_data unchanged.
- done and err are high only in DONE; err is 0 on successful completion.
- Back-to-back requests: req held high is re-accepted in the IDLE cycle after DONE, so the minimum spacing is one idle cycle.

Test Plan:
- Word at index 5 = 32'h8234_56F0. Load byte, addr=0x17, unsigned_ld=0 -> one READ cycle with Address=5; done in cycle 2; load_data=32'hFFFF_FF82. Repeat with unsigned_ld=1 -> 32'h0000_0082.
- Word at index 3 = 32'hAABB_CCDD. Store half, addr=0x0E, store_data=32'h1234_5678 -> READ, then WRITE with Write_data=32'h5678_CCDD; MemWrite high exactly one cycle; done in cycle 3.
- Store word, addr=0x20, store_data=32'hDEAD_BEEF -> no MemRead; WRITE with Address=8; memory word 8 = DEADBEEF; load_data unchanged.
- Load word addr=0x02, load half addr=0x03, size=11, and addr=0x100 with CHECK_RANGE=1 -> each gives done and err=1 in cycle 1 with MemRead=MemWrite=0.
- Assert reset in the READ cycle of a sub-word store -> next cycle IDLE with all outputs 0, no MemWrite ever issued, memory unchanged.
- req held high for three loads from indices 0, 1, 2 -> accepts spaced 3 cycles apart; pulses on req during busy are ignored.
